// File: rtl/recip_pkg.sv
// rtl/recip_pkg.sv - shared state encoding and sizing helpers for the reciprocal range controller
package recip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    WAIT,
    DENORM,
    OUT
  } state_t;

  localparam int P_DEF = 22;
  localparam int W_DEF = P_DEF + 3;
  localparam logic [W_DEF-1:0] SAT_ONES = '1;

  // Signed shift count must reach +(P+1) and -1 without wrapping.
  function automatic int k_width(input int p);
    return $clog2(p + 3) + 1;
  endfunction

  function automatic int cnt_width(input int lat);
    return $clog2(lat + 2);
  endfunction

  localparam int K_W   = k_width(P_DEF);
  localparam int CNT_W = cnt_width(1);

endpackage

// File: rtl/lut_recip_range_ctrl.sv
// rtl/lut_recip_range_ctrl.sv - normalise operand into [2,4), drive the LUT core, denormalise 1/x
module lut_recip_range_ctrl
  import recip_pkg::*;
#(
  parameter int P        = P_DEF,
  parameter int CORE_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P+2:0] in_x,
  output logic [P+2:0] core_x,
  input  logic [P+2:0] core_recip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P+2:0] out_recip,
  output logic         out_dz,
  output logic         out_ovf
);

  localparam int W  = P + 3;
  localparam int KW = k_width(P);
  localparam int CW = cnt_width(CORE_LAT);
  localparam logic signed [KW-1:0] K_ONE   = KW'(1);
  localparam logic signed [KW-1:0] K_M1    = '1;
  localparam logic [CW-1:0]        CNT_END = CW'(CORE_LAT);

  state_t                 state, state_n;
  logic [W-1:0]           xn, xn_n;
  logic [W-1:0]           r, r_n;
  logic [W-1:0]           recip_n;
  logic signed [KW-1:0]   k, k_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   dz_n, ovf_n;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign core_x    = xn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xn        <= '0;
      r         <= '0;
      k         <= '0;
      cnt       <= '0;
      out_recip <= '0;
      out_dz    <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      xn        <= xn_n;
      r         <= r_n;
      k         <= k_n;
      cnt       <= cnt_n;
      out_recip <= recip_n;
      out_dz    <= dz_n;
      out_ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    xn_n    = xn;
    r_n     = r;
    k_n     = k;
    cnt_n   = cnt;
    recip_n = out_recip;
    dz_n    = out_dz;
    ovf_n   = out_ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          xn_n    = in_x;
          k_n     = '0;
          state_n = NORM;
        end
      end
      NORM: begin
        if (xn == '0) begin
          recip_n = '1;
          dz_n    = 1'b1;
          state_n = OUT;
        end else if (xn[P+2]) begin
          xn_n = xn >> 1;
          k_n  = K_M1;
        end else if (xn[P+1]) begin
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          xn_n = xn << 1;
          k_n  = k + K_ONE;
        end
      end
      WAIT: begin
        if (cnt == CNT_END) begin
          r_n     = core_recip;
          state_n = DENORM;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DENORM: begin
        // Sign bit set means k == -1, the only negative count possible.
        if (k == '0) begin
          recip_n = r;
          state_n = OUT;
        end else if (k[KW-1]) begin
          r_n = r >> 1;
          k_n = '0;
        end else if (r[P+2]) begin
          recip_n = '1;
          ovf_n   = 1'b1;
          state_n = OUT;
        end else begin
          r_n = r << 1;
          k_n = k - K_ONE;
        end
      end
      OUT: begin
        if (out_ready) begin
          dz_n    = 1'b0;
          ovf_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lut_recip_range_ctrl.sv
// tb/tb_lut_recip_range_ctrl.sv - directed vectors for lut_recip_range_ctrl with an exact core model
module recip_core_model #(
  parameter int P        = 22,
  parameter int CORE_LAT = 1
) (
  input  logic         clk,
  input  logic [P+2:0] x,
  output logic [P+2:0] recip
);

  logic [P+2:0] pipe [CORE_LAT];

  function automatic logic [P+2:0] f(input logic [P+2:0] v);
    logic [63:0] q;
    if (v == '0) return '1;
    q = (64'd1 << (2 * P)) / 64'(v);
    return q[P+2:0];
  endfunction

  initial begin
    for (int i = 0; i < CORE_LAT; i++) pipe[i] = '0;
  end

  always @(posedge clk) begin
    pipe[0] <= f(x);
    for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign recip = pipe[CORE_LAT-1];

endmodule

module tb_lut_recip_range_ctrl;

  localparam int P = 22;
  localparam int CORE_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [P+2:0]  in_x;
  logic [P+2:0]  core_x;
  logic [P+2:0]  core_recip;
  logic          out_valid;
  logic          out_ready;
  logic [P+2:0]  out_recip;
  logic          out_dz;
  logic          out_ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  lut_recip_range_ctrl #(.P(P), .CORE_LAT(CORE_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .core_x     (core_x),
    .core_recip (core_recip),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_recip  (out_recip),
    .out_dz     (out_dz),
    .out_ovf    (out_ovf)
  );

  recip_core_model #(.P(P), .CORE_LAT(CORE_LAT)) core (
    .clk   (clk),
    .x     (core_x),
    .recip (core_recip)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input string tag, input logic [P+2:0] x);
    @(negedge clk);
    in_x     = x;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // n counts cycles from the accept edge; the cycle right after it is 1.
  task automatic wait_out(input string tag, output int n);
    n = 1;
    while (!out_valid && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [P+2:0] x, input logic [P+2:0] exp_recip,
                        input logic exp_dz, input logic exp_ovf, input int exp_lat);
    int n;
    start_op(tag, x);
    wait_out(tag, n);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_recip"}, 32'(out_recip), 32'(exp_recip));
    chk({tag, "_dz"}, 32'(out_dz), 32'(exp_dz));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    @(posedge clk);
    #1;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_recip"}, 32'(out_recip), 32'd0);
    chk({tag, "_flags"}, 32'({out_dz, out_ovf}), 32'd0);
    chk({tag, "_core_x"}, 32'(core_x), 32'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("two",    25'h0800000, 25'h0200000, 1'b0, 1'b0, 5);
    run_op("one",    25'h0400000, 25'h0400000, 1'b0, 1'b0, 7);
    run_op("half",   25'h0200000, 25'h0800000, 1'b0, 1'b0, 9);
    run_op("four",   25'h1000000, 25'h0100000, 1'b0, 1'b0, 7);
    run_op("max",    25'h1FFFFFF, 25'h0080000, 1'b0, 1'b0, 7);
    run_op("zero",   25'h0000000, 25'h1FFFFFF, 1'b1, 1'b0, 2);
    run_op("lsb",    25'h0000001, 25'h1FFFFFF, 1'b0, 1'b1, -1);

    // Output stall: result and flags frozen, new operands ignored.
    out_ready = 1'b0;
    start_op("stall", 25'h0800000);
    wait_out("stall", n);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_x     = 25'h0400000;
      @(posedge clk);
      #1;
      chk("stall_hold_recip", 32'(out_recip), 32'h0200000);
      chk("stall_hold_flags", 32'({out_valid, out_dz, out_ovf}), 32'b100);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    run_op("b2b", 25'h0400000, 25'h0400000, 1'b0, 1'b0, 7);

    // Reset while the core is being waited on.
    start_op("abort", 25'h0400000);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 25'h0800000, 25'h0200000, 1'b0, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
